// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the bubble instruction, default reset PC and PC helper functions.
package if_fetch_stage_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_e;

  // Force word alignment of an address.
  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Next sequential PC; wraps from 32'hFFFF_FFFC to 0.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc_align(pc) + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. bubble_i inserts a NOP with valid=0 and wins over
// load_i; with neither asserted the register holds its contents.
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               bubble_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc_plus4_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_plus4_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [31:0]        pc_plus4_d, pc_plus4_q;
  logic               valid_d, valid_q;

  // Select bubble, new instruction or hold for the next register contents.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (bubble_i) begin
      instr_d    = NOP_INSTR;
      pc_plus4_d = 32'h0000_0000;
      valid_d    = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
      valid_d    = 1'b1;
    end else begin
      instr_d    = instr_q;
    end
  end

  // IF/ID storage with synchronous reset to an empty bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: PC, fetch FSM (FETCH/HOLD/DROP), holding
// buffer for instructions returned during a stall, and the IF/ID register.
// Optional feature macro IF_STALL_CNT_EN adds stall_cnt_o, a saturating count
// of cycles in which IF/ID is not loaded with a valid instruction.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               PCWrite_i,
  input  logic               IFIDWrite_i,
  input  logic               flush_i,
  input  logic [31:0]        branch_target_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_plus4_o,
`ifdef IF_STALL_CNT_EN
  output logic               valid_o,
  output logic [31:0]        stall_cnt_o
`else
  output logic               valid_o
`endif
);

  fetch_state_e       state_d, state_q;
  logic [31:0]        pc_d, pc_q;
  logic [INSTR_W-1:0] buf_d, buf_q;
  logic [31:0]        drop_addr_d, drop_addr_q;
  logic               hold_s;
  logic               load_s;
  logic               bubble_s;
  logic [INSTR_W-1:0] load_instr_s;

  assign hold_s = PCWrite_i | IFIDWrite_i;

  // Next-state, PC, buffer and IF/ID control; flush has top priority.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    drop_addr_d  = drop_addr_q;
    load_s       = 1'b0;
    bubble_s     = 1'b0;
    load_instr_s = imem_rdata_i;
    if (flush_i) begin
      pc_d     = pc_align(branch_target_i);
      bubble_s = 1'b1;
      buf_d    = NOP_INSTR;
      case (state_q)
        ST_FETCH: begin
          if (imem_ack_i) begin
            state_d = ST_FETCH;
          end else begin
            // Outstanding request must still complete at its own address.
            state_d     = ST_DROP;
            drop_addr_d = pc_q;
          end
        end
        ST_HOLD:  state_d = ST_FETCH;
        ST_DROP: begin
          if (imem_ack_i) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DROP;
          end
        end
        default:  state_d = ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ack_i && !hold_s) begin
            load_s = 1'b1;
            pc_d   = pc_inc(pc_q);
          end else if (imem_ack_i) begin
            buf_d   = imem_rdata_i;
            state_d = ST_HOLD;
          end else if (!hold_s) begin
            bubble_s = 1'b1;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_HOLD: begin
          load_instr_s = buf_q;
          if (!hold_s) begin
            load_s  = 1'b1;
            pc_d    = pc_inc(pc_q);
            state_d = ST_FETCH;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_DROP: begin
          if (imem_ack_i) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_DROP;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // State, PC, holding buffer and abandoned-address registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_FETCH;
      pc_q        <= pc_align(RESET_PC);
      buf_q       <= NOP_INSTR;
      drop_addr_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  // Request is live in FETCH and DROP; DROP keeps the abandoned address.
  assign imem_req_o  = !rst_i && (state_q != ST_HOLD);
  assign imem_addr_o = (state_q == ST_DROP) ? drop_addr_q : pc_q;

  if_id_reg u_if_id_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_s),
    .bubble_i   (bubble_s),
    .instr_i    (load_instr_s),
    .pc_plus4_i (pc_inc(pc_q)),
    .instr_o    (instr_o),
    .pc_plus4_o (pc_plus4_o),
    .valid_o    (valid_o)
  );

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Saturating count of cycles where IF/ID takes no valid instruction.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!load_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch front end of the five-stage MIPS pipeline: owns the PC, issues requests to a variable-latency instruction memory, and drives the IF/ID pipeline register that feeds the decode stage and the hazard detection unit. It honours the load-use hold from hazard detection and the branch redirect/flush from ID. Handshake-tolerant so a cached or multi-cycle instruction memory can be used without changing downstream stages.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- PCWrite_i  in  1  hazard unit: 1 = hold PC (load-use stall)
- IFIDWrite_i  in  1  hazard unit: 1 = hold IF/ID register
- flush_i  in  1  ID stage: branch/jump taken, redirect fetch and flush IF/ID
- branch_target_i  in  32  redirect address, valid when flush_i=1
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address (word-aligned)
- imem_ack_i  in  1  request accepted, imem_rdata_i valid this cycle
- imem_rdata_i  in  32  fetched instruction
- instr_o  out  32  IF/ID instruction
- pc_plus4_o  out  32  IF/ID PC+4
- valid_o  out  1  IF/ID holds a real instruction (0 = bubble)
- stall_cnt_o  out  32  present only with IF_STALL_CNT_EN

## Operation
- hold = PCWrite_i | IFIDWrite_i; PC and IF/ID are always held together.
- FSM states: FETCH, HOLD, DROP.
- FETCH: imem_req_o=1, imem_addr_o=pc.
  - ack & !hold: IF/ID <= {rdata, pc+4, 1}; pc <= pc+4; stay FETCH.
  - ack & hold: rdata -> holding buffer; IF/ID unchanged; go HOLD.
  - !ack & !hold: IF/ID <= bubble {NOP=0, 0, 0}; stay FETCH.
  - !ack & hold: no change.
- HOLD: imem_req_o=0. When hold drops: IF/ID <= {buffer, pc+4, 1}; pc <= pc+4; go FETCH.
- DROP: imem_req_o=1, imem_addr_o = the abandoned address; on ack discard data, go FETCH; IF/ID stays bubble.
- flush_i (priority over hold and ack): pc <= branch_target_i; IF/ID <= bubble; buffer discarded.
  - FETCH with !ack -> DROP; FETCH with ack -> FETCH (data discarded); HOLD -> FETCH; DROP -> DROP (new target kept, old request still completed).
- Request stability: once imem_req_o=1, imem_addr_o is unchanged until the cycle imem_ack_i=1.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 0; bits [1:0] forced 0.

## Timing
- Reset values: pc=RESET_PC, state=FETCH, imem_req_o=0 while rst_i=1, instr_o=0, pc_plus4_o=0, valid_o=0, stall_cnt_o=0.
- First cycle after reset release: imem_req_o=1, imem_addr_o=RESET_PC.
- Zero-wait memory (ack in request cycle): one instruction per cycle, IF/ID valid one edge after ack.
- Redirect: first request to branch_target_i issued the cycle after flush_i if no request outstanding; otherwise the cycle after the abandoned request is acked.
- Hold released: buffered instruction appears in IF/ID on the first edge with hold=0; no refetch.
- Reset mid-request: request abandoned, late acks ignored, FSM restarts at FETCH.

## Configuration
- IF_STALL_CNT_EN defined: stall_cnt_o counts cycles with valid_o written 0 or IF/ID held (saturates at 32'hFFFF_FFFF, cleared by rst_i).
- Undefined: port and counter absent; no other behaviour change.

## Structure
- Shared package: FSM state enum (FETCH/HOLD/DROP), NOP constant 32'h0, RESET_PC default, instruction width constant.
- One sub-module: if_id_reg (IF/ID register with load, hold, and bubble-insert controls); FSM, PC and holding buffer stay in the top.

## Test plan
- Reset, ack always 1 -> addresses 0,4,8,...; IF/ID valid one cycle after each ack; pc_plus4_o 4,8,12.
- Ack delayed 3 cycles at addr 8 -> imem_addr_o stable at 8 for 4 cycles; valid_o=0 for 3 cycles then instr@8.
- PCWrite_i=IFIDWrite_i=1 for 2 cycles while ack of addr 16 arrives -> req drops, IF/ID unchanged, instr@16 delivered on release, next request 20.
- flush_i with target 0x100 while request to 0x24 outstanding -> 0x24 data discarded, next request 0x100, no valid_o with 0x24 data.
- flush_i and hold same cycle -> IF/ID bubble, pc=target.
- IF_STALL_CNT_EN: 5 bubble/hold cycles -> stall_cnt_o=5; rst_i -> 0.
